// File: rtl/dla_clock_cross_toggle_req_if.sv
// Source-side handshake bundle for the toggle-request clock crossing.
interface dla_clock_cross_toggle_req_if #(
   parameter int unsigned WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data;
   logic [WIDTH-1:0] o_data;
   logic             o_req_toggle;
   logic             i_ack_sync;
   logic             o_done;
   logic             o_busy;
   logic             o_protocol_err;

   // Controller side: consumes the upstream payload and the synchronized ack.
   modport slave (
      input  i_valid, i_data, i_ack_sync,
      output o_ready, o_data, o_req_toggle, o_done, o_busy, o_protocol_err
   );

   // Upstream producer side.
   modport master (
      output i_valid, i_data, i_ack_sync,
      input  o_ready, o_data, o_req_toggle, o_done, o_busy, o_protocol_err
   );
endinterface

// File: rtl/dla_clock_cross_toggle_req.sv
// Source-domain controller for a toggle-handshake payload crossing: captures a
// payload, holds it quasi-static, flips a request level after a settle delay.
module dla_clock_cross_toggle_req #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           i_async_resetn,
   dla_clock_cross_toggle_req_if.slave    bus
);
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      WAIT_ACK = 2'd2
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic [WIDTH-1:0] data_q;
   logic             req_q;
   logic             done_q;
   logic             busy_q;
   logic             err_q;

   // Before the flip the returning ack must still match the current request level.
   always_ff @(posedge clk or negedge i_async_resetn) begin
      if (!i_async_resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         data_q  <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if ((state_q != WAIT_ACK) && (bus.i_ack_sync != req_q)) begin
            err_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (bus.i_valid && ready_q) begin
                  data_q  <= bus.i_data;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (SETTLE_CYCLES == 0) begin
                     req_q   <= ~req_q;
                     state_q <= WAIT_ACK;
                  end else begin
                     cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                     state_q <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  req_q   <= ~req_q;
                  state_q <= WAIT_ACK;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            WAIT_ACK: begin
               if (bus.i_ack_sync == req_q) begin
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_ready        = ready_q;
   assign bus.o_data         = data_q;
   assign bus.o_req_toggle   = req_q;
   assign bus.o_done         = done_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_protocol_err = err_q;
endmodule

// File: tb/tb_dla_clock_cross_toggle_req.sv
// Directed bench for the toggle-request source controller (settle 2 and settle 0).
module tb_dla_clock_cross_toggle_req;
   localparam int unsigned WIDTH = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   dla_clock_cross_toggle_req_if #(.WIDTH(WIDTH)) bus_a ();
   dla_clock_cross_toggle_req_if #(.WIDTH(WIDTH)) bus_b ();

   dla_clock_cross_toggle_req #(.WIDTH(WIDTH), .SETTLE_CYCLES(2)) u_dut_a (
      .clk            (clk),
      .i_async_resetn (rst_n),
      .bus            (bus_a.slave)
   );

   dla_clock_cross_toggle_req #(.WIDTH(WIDTH), .SETTLE_CYCLES(0)) u_dut_b (
      .clk            (clk),
      .i_async_resetn (rst_n),
      .bus            (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, ".a_ready"}, 64'(bus_a.o_ready), 64'd1);
      check({tag, ".a_data"},  64'(bus_a.o_data), 64'd0);
      check({tag, ".a_req"},   64'(bus_a.o_req_toggle), 64'd0);
      check({tag, ".a_done"},  64'(bus_a.o_done), 64'd0);
      check({tag, ".a_busy"},  64'(bus_a.o_busy), 64'd0);
      check({tag, ".a_err"},   64'(bus_a.o_protocol_err), 64'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus_a.i_valid = 1'b0; bus_a.i_data = '0; bus_a.i_ack_sync = 1'b0;
      bus_b.i_valid = 1'b0; bus_b.i_data = '0; bus_b.i_ack_sync = 1'b0;
      repeat (3) tick();
      check_reset_a("rst");
      check("rst.b_req", 64'(bus_b.o_req_toggle), 64'd0);
      rst_n = 1'b1;

      // Idle with ack low stays quiet.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle.ready", 64'(bus_a.o_ready), 64'd1);
         check("idle.req",   64'(bus_a.o_req_toggle), 64'd0);
         check("idle.busy",  64'(bus_a.o_busy), 64'd0);
         check("idle.err",   64'(bus_a.o_protocol_err), 64'd0);
      end

      // Settle 2: capture at T, flip at T+2, done one cycle after ack.
      bus_a.i_valid = 1'b1; bus_a.i_data = 32'hDEADBEEF;
      tick();
      bus_a.i_valid = 1'b0; bus_a.i_data = 32'h0;
      check("t1.data",  64'(bus_a.o_data), 64'hDEADBEEF);
      check("t1.ready", 64'(bus_a.o_ready), 64'd0);
      check("t1.busy",  64'(bus_a.o_busy), 64'd1);
      check("t1.req0",  64'(bus_a.o_req_toggle), 64'd0);
      tick();
      check("t1.req1",  64'(bus_a.o_req_toggle), 64'd0);
      tick();
      check("t1.req2",  64'(bus_a.o_req_toggle), 64'd1);
      check("t1.data2", 64'(bus_a.o_data), 64'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1.wait_done", 64'(bus_a.o_done), 64'd0);
         check("t1.wait_busy", 64'(bus_a.o_busy), 64'd1);
      end
      bus_a.i_ack_sync = 1'b1;
      tick();
      check("t1.done",  64'(bus_a.o_done), 64'd1);
      check("t1.rdy",   64'(bus_a.o_ready), 64'd1);
      check("t1.nbusy", 64'(bus_a.o_busy), 64'd0);
      tick();
      check("t1.done_pulse", 64'(bus_a.o_done), 64'd0);

      // Back-to-back with valid held high.
      bus_a.i_valid = 1'b1; bus_a.i_data = 32'h1;
      tick();
      bus_a.i_data = 32'h2;
      check("b2b.data1", 64'(bus_a.o_data), 64'h1);
      tick();
      check("b2b.req_hold", 64'(bus_a.o_req_toggle), 64'd1);
      tick();
      check("b2b.req_flip", 64'(bus_a.o_req_toggle), 64'd0);
      tick();
      check("b2b.data1_hold", 64'(bus_a.o_data), 64'h1);
      bus_a.i_ack_sync = 1'b0;
      tick();
      check("b2b.done1",  64'(bus_a.o_done), 64'd1);
      check("b2b.data_d", 64'(bus_a.o_data), 64'h1);
      tick();
      check("b2b.data2",  64'(bus_a.o_data), 64'h2);
      check("b2b.ready2", 64'(bus_a.o_ready), 64'd0);
      check("b2b.done_lo", 64'(bus_a.o_done), 64'd0);
      bus_a.i_valid = 1'b0;
      tick();
      tick();
      check("b2b.req2", 64'(bus_a.o_req_toggle), 64'd1);
      bus_a.i_ack_sync = 1'b1;
      tick();
      check("b2b.done2", 64'(bus_a.o_done), 64'd1);
      check("b2b.err",   64'(bus_a.o_protocol_err), 64'd0);

      // Settle 0: flip on the capture edge.
      bus_b.i_valid = 1'b1; bus_b.i_data = 32'hCAFEF00D;
      tick();
      bus_b.i_valid = 1'b0;
      check("s0.data",  64'(bus_b.o_data), 64'hCAFEF00D);
      check("s0.req",   64'(bus_b.o_req_toggle), 64'd1);
      check("s0.ready", 64'(bus_b.o_ready), 64'd0);
      check("s0.busy",  64'(bus_b.o_busy), 64'd1);
      tick();
      check("s0.nodone", 64'(bus_b.o_done), 64'd0);
      bus_b.i_ack_sync = 1'b1;
      tick();
      check("s0.done",  64'(bus_b.o_done), 64'd1);
      check("s0.rdy",   64'(bus_b.o_ready), 64'd1);
      tick();
      check("s0.done_lo", 64'(bus_b.o_done), 64'd0);
      check("s0.err",     64'(bus_b.o_protocol_err), 64'd0);

      // Unexpected ack edge in IDLE sets a sticky error.
      bus_a.i_ack_sync = 1'b0;
      tick();
      check("perr.set", 64'(bus_a.o_protocol_err), 64'd1);
      bus_a.i_ack_sync = 1'b1;
      tick();
      check("perr.hold", 64'(bus_a.o_protocol_err), 64'd1);
      bus_a.i_valid = 1'b1; bus_a.i_data = 32'h55;
      tick();
      bus_a.i_valid = 1'b0;
      tick();
      tick();
      check("perr.req", 64'(bus_a.o_req_toggle), 64'd0);
      bus_a.i_ack_sync = 1'b0;
      tick();
      check("perr.done",  64'(bus_a.o_done), 64'd1);
      check("perr.still", 64'(bus_a.o_protocol_err), 64'd1);

      // Reset while waiting for ack clears everything at once.
      bus_a.i_valid = 1'b1; bus_a.i_data = 32'h77;
      tick();
      bus_a.i_valid = 1'b0;
      tick();
      tick();
      check("ra.wait_req",  64'(bus_a.o_req_toggle), 64'd1);
      check("ra.wait_busy", 64'(bus_a.o_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_a("ra");
      check("ra.b_req", 64'(bus_b.o_req_toggle), 64'd0);
      bus_a.i_ack_sync = 1'b0;
      bus_b.i_ack_sync = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      bus_a.i_valid = 1'b1; bus_a.i_data = 32'hA5A5A5A5;
      tick();
      bus_a.i_valid = 1'b0;
      check("pr.data", 64'(bus_a.o_data), 64'hA5A5A5A5);
      tick();
      tick();
      check("pr.req", 64'(bus_a.o_req_toggle), 64'd1);
      bus_a.i_ack_sync = 1'b1;
      tick();
      check("pr.done", 64'(bus_a.o_done), 64'd1);
      check("pr.err",  64'(bus_a.o_protocol_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
